testport_snoop: RTL
===================

TESTPORT_SNOOP -- requirements
Module: testport_snoop

Interface
REQ-001 Parameter TEST_PORT, 30'h3FF, word address of the test output port.
REQ-002 Parameter BEGIN_SYMBOL, 32'h00000168, frame-start marker (readable byte order).
REQ-003 Parameter END_SYMBOL, 32'hFFFFFD5D, frame-end marker (readable byte order).
REQ-004 Parameter FIFO_DEPTH, 8, output buffer entries (power of two, >=2).
REQ-005 clk  input  1  single clock, all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 addr  input  30  data-memory bus word address.
REQ-008 data  input  32  data-memory bus write data, little-endian byte order.
REQ-009 wen  input  1  data-memory bus write enable; may stay high for many cycles during a cache stall.
REQ-010 out_ready  input  1  downstream checker accepts the head word.
REQ-011 out_valid  output  1  head word available.
REQ-012 out_data  output  32  captured word, byte-swapped to readable order.
REQ-013 out_index  output  10  position of the word within the frame, 0-based.
REQ-014 out_last  output  1  head word is END_SYMBOL.
REQ-015 frame_active  output  1  high between BEGIN and END capture.
REQ-016 frame_done  output  1  sticky, END_SYMBOL captured.
REQ-017 overflow  output  1  sticky, a word was dropped on a full FIFO.
REQ-018 word_count  output  10  words pushed in the current frame.

Function
REQ-019 Write-edge filter: a capture event SHALL occur in cycle t iff wen=1, addr=TEST_PORT, and the filter is armed; the filter SHALL disarm on any wen=1 cycle and re-arm only after a wen=0 cycle, so one stalled write yields exactly one event.
REQ-020 Captured word SHALL be {data[7:0],data[15:8],data[23:16],data[31:24]}.
REQ-021 FSM states IDLE, ACTIVE, DONE; IDLE->ACTIVE on an event whose word equals BEGIN_SYMBOL; the BEGIN word SHALL NOT be pushed; other events in IDLE SHALL be ignored.
REQ-022 In ACTIVE each event SHALL push {word, word_count, word==END_SYMBOL} and increment word_count (saturating at 1023).
REQ-023 ACTIVE->DONE when the pushed word equals END_SYMBOL; frame_done SHALL rise the following cycle; BEGIN_SYMBOL seen in ACTIVE SHALL be pushed as ordinary data.
REQ-024 DONE SHALL ignore all events and hold until rst; FIFO continues to drain.
REQ-025 Push-to-out_valid latency SHALL be 1 cycle when the FIFO was empty (registered storage, no bypass).
REQ-026 Pop occurs when out_valid && out_ready; out_data/out_index/out_last SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 Push when full with no simultaneous pop SHALL drop the word, still increment word_count, and set overflow.
REQ-028 Simultaneous push and pop when full SHALL succeed with no drop; simultaneous push and pop when empty SHALL leave the FIFO holding the new word.
REQ-029 Read/write pointers SHALL wrap modulo FIFO_DEPTH; full/empty distinguished by an extra pointer bit.

Reset
REQ-030 On rst=1 at a rising edge: FSM=IDLE, filter armed, FIFO empty, out_valid=0, out_data=0, out_index=0, out_last=0, frame_active=0, frame_done=0, overflow=0, word_count=0.
REQ-031 rst mid-frame SHALL discard buffered words; an event in the reset cycle SHALL be ignored.

Structure
REQ-032 Shared package SHALL hold TEST_PORT, BEGIN_SYMBOL, END_SYMBOL, the byte-swap function, and the FSM state encoding, shared with the checker.
REQ-033 FIFO SHALL be a sub-module snoop_fifo (width 43, depth FIFO_DEPTH); filter and FSM live in the top.

Verification
REQ-034 wen held 5 cycles at 0x3FF with data 32'h68010000 in IDLE -> one event, frame_active=1 next cycle, nothing pushed.
REQ-035 Frame of words 0,1,2 then END, out_ready=1 -> out_data 0,1,2,FFFFFD5D with out_index 0..3, out_last only on the 4th, frame_done=1.
REQ-036 Writes to addr 0x3FE during ACTIVE -> no events, word_count unchanged.
REQ-037 out_ready=0, 10 captures in ACTIVE -> 8 buffered, overflow=1, word_count=10; then drain -> indices 0..7 in order.
REQ-038 Full FIFO with push and pop same cycle -> overflow stays 0, occupancy stays 8.
REQ-039 rst asserted after 3 buffered words -> next cycle out_valid=0, FSM IDLE, new BEGIN restarts indices at 0.

Source files
------------

// File: rtl/testport_snoop_pkg.sv
// Constants, state encoding and helpers shared by the test-port snooper and its checker.
package testport_snoop_pkg;

  localparam logic [29:0] TestPort    = 30'h3FF;
  localparam logic [31:0] BeginSymbol = 32'h0000_0168;
  localparam logic [31:0] EndSymbol   = 32'hFFFF_FD5D;

  typedef enum logic [1:0] {StIdle, StActive, StDone} snoop_state_e;

  typedef struct packed {
    logic [31:0] word;
    logic [9:0]  index;
    logic        last;
  } snoop_entry_t;

  localparam int unsigned EntryWidth = $bits(snoop_entry_t);

  // Bus data is little-endian; markers are compared in readable byte order.
  function automatic logic [31:0] byte_swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/snoop_fifo.sv
// Registered-storage FIFO; pointers carry an extra wrap bit to tell full from empty.
module snoop_fifo #(
  parameter int unsigned Width = 43,
  parameter int unsigned Depth = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic             empty,
  output logic             drop,
  output logic [Width-1:0] pop_data
);

  localparam int unsigned Aw = $clog2(Depth);
  localparam logic [Aw:0] PtrOne = 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Aw:0]      wptr_q, rptr_q;
  logic             full, do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[Aw] != rptr_q[Aw]) && (wptr_q[Aw-1:0] == rptr_q[Aw-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop)  rptr_q <= rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[Aw-1:0]] <= push_data;
  end

  assign pop_data = empty ? '0 : mem_q[rptr_q[Aw-1:0]];

endmodule

// File: rtl/testport_snoop.sv
// Snoops data-memory writes to the test port, frames them between BEGIN/END markers
// and buffers the framed words for a downstream checker.
module testport_snoop
  import testport_snoop_pkg::*;
#(
  parameter logic [29:0] TEST_PORT    = TestPort,
  parameter logic [31:0] BEGIN_SYMBOL = BeginSymbol,
  parameter logic [31:0] END_SYMBOL   = EndSymbol,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] addr,
  input  logic [31:0] data,
  input  logic        wen,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [9:0]  out_index,
  output logic        out_last,
  output logic        frame_active,
  output logic        frame_done,
  output logic        overflow,
  output logic [9:0]  word_count
);

  snoop_state_e state_q, state_d;
  logic         armed_q;
  logic [9:0]   word_count_q, word_count_d;
  logic         overflow_q;
  logic         capture, push, fifo_empty, fifo_drop;
  logic [31:0]  word;
  logic         is_end;
  snoop_entry_t push_entry, pop_entry;

  // A stalled write holds wen high; only its first cycle may produce an event.
  assign capture = wen && (addr == TEST_PORT) && armed_q;
  assign word    = byte_swap(data);
  assign is_end  = (word == END_SYMBOL);

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (capture && (word == BEGIN_SYMBOL)) state_d = StActive;
      end
      StActive: begin
        if (capture) begin
          push = 1'b1;
          if (is_end) state_d = StDone;
        end
      end
      StDone: ;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    word_count_d = word_count_q;
    if (push && (word_count_q != 10'h3FF)) word_count_d = word_count_q + 10'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      armed_q      <= 1'b1;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      armed_q      <= !wen;
      word_count_q <= word_count_d;
      if (fifo_drop) overflow_q <= 1'b1;
    end
  end

  assign push_entry = '{word: word, index: word_count_q, last: is_end};

  snoop_fifo #(
    .Width (EntryWidth),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (out_valid && out_ready),
    .empty     (fifo_empty),
    .drop      (fifo_drop),
    .pop_data  (pop_entry)
  );

  assign out_valid    = !fifo_empty;
  assign out_data     = pop_entry.word;
  assign out_index    = pop_entry.index;
  assign out_last     = pop_entry.last;
  assign frame_active = (state_q == StActive);
  assign frame_done   = (state_q == StDone);
  assign overflow     = overflow_q;
  assign word_count   = word_count_q;

endmodule
